// File: rtl/conv_rd_addr_gen.sv
// conv_rd_addr_gen: frame-level pixel read sequencer feeding the conv read bridge.
// Walks an IMG_W x IMG_H grid, issuing one pixel address at a time. It waits for
// the rising edge of the bridge's in_valid, then drops the address for exactly
// one cycle before moving to the next pixel. At the end of the frame it pulses
// frame_done.
module conv_rd_addr_gen #(
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32,
  parameter logic [27:0] PIX_STRIDE = 28'h040,
  parameter logic [27:0] ROW_PITCH  = 28'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [27:0] base_addr,
  input  logic        conv_ready,
  input  logic        in_valid,
  output logic [27:0] rd_addr,
  output logic        addr_ena,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        busy,
  output logic        frame_done
);

  // Last column/row indices; the GAP cycle compares against these to decide
  // between a column step, a row step and end of frame.
  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [27:0] row_base_r;
  logic [27:0] row_base_s;
  logic [27:0] pix_ptr_r;
  logic [27:0] pix_ptr_s;
  logic [9:0]  pix_x_r;
  logic [9:0]  pix_x_s;
  logic [9:0]  pix_y_r;
  logic [9:0]  pix_y_s;
  logic        in_valid_q_r;
  logic        in_valid_rise_s;

  logic [27:0] rd_addr_s;
  logic        addr_ena_s;
  logic        busy_s;
  logic        frame_done_s;

  // A level-high in_valid counts only once, so completion is its rising edge.
  // The previous-cycle copy is kept in every state, which means a level that is
  // already high when WAIT is entered does not look like a new edge.
  assign in_valid_rise_s = in_valid & ~in_valid_q_r;

  // State, pointer and in_valid history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      row_base_r   <= 28'h000_0000;
      pix_ptr_r    <= 28'h000_0000;
      pix_x_r      <= 10'd0;
      pix_y_r      <= 10'd0;
      in_valid_q_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      row_base_r   <= row_base_s;
      pix_ptr_r    <= pix_ptr_s;
      pix_x_r      <= pix_x_s;
      pix_y_r      <= pix_y_s;
      in_valid_q_r <= in_valid;
    end
  end

  // Next-state, pointer-update and bridge-facing output decode.
  always_comb begin
    state_s      = state_r;
    row_base_s   = row_base_r;
    pix_ptr_s    = pix_ptr_r;
    pix_x_s      = pix_x_r;
    pix_y_s      = pix_y_r;
    rd_addr_s    = 28'h000_0000;
    addr_ena_s   = 1'b0;
    busy_s       = 1'b0;
    frame_done_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          row_base_s = base_addr;
          pix_ptr_s  = base_addr;
          pix_x_s    = 10'd0;
          pix_y_s    = 10'd0;
          state_s    = ST_ISSUE;
        end else begin
          state_s    = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        busy_s = 1'b1;
        // The request goes out in the same cycle conv_ready is seen, so the
        // address appears without an extra cycle of latency.
        if (conv_ready) begin
          rd_addr_s  = pix_ptr_r;
          addr_ena_s = 1'b1;
          state_s    = ST_WAIT;
        end else begin
          state_s    = ST_ISSUE;
        end
      end

      ST_WAIT: begin
        // conv_ready is not looked at here: once a pixel is requested it
        // stays outstanding until the bridge reports it complete.
        busy_s     = 1'b1;
        rd_addr_s  = pix_ptr_r;
        addr_ena_s = 1'b1;
        if (in_valid_rise_s) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_GAP: begin
        // One idle cycle on the address lines lets the bridge clear its
        // address before the next pixel. The pointers advance here.
        busy_s = 1'b1;
        if (pix_x_r != X_LAST) begin
          pix_x_s   = pix_x_r + 10'd1;
          pix_ptr_s = pix_ptr_r + PIX_STRIDE;
          state_s   = ST_ISSUE;
        end else if (pix_y_r != Y_LAST) begin
          // Rows may be padded, so the next row starts from the previous
          // row base rather than from the end of the previous row.
          pix_x_s    = 10'd0;
          pix_y_s    = pix_y_r + 10'd1;
          row_base_s = row_base_r + ROW_PITCH;
          pix_ptr_s  = row_base_r + ROW_PITCH;
          state_s    = ST_ISSUE;
        end else begin
          // Last pixel: the coordinates stay on it until the next start.
          state_s = ST_DONE;
        end
      end

      ST_DONE: begin
        frame_done_s = 1'b1;
        state_s      = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign rd_addr    = rd_addr_s;
  assign addr_ena   = addr_ena_s;
  assign busy       = busy_s;
  assign frame_done = frame_done_s;
  assign pix_x      = pix_x_r;
  assign pix_y      = pix_y_r;

endmodule

// File: tb/tb_conv_rd_addr_gen.sv
// Self-checking bench for conv_rd_addr_gen.
// Three instances cover different geometries: a 3x2 padded-row grid, a 1-wide
// 3-row column and a single pixel. Stimulus (stalls, in_valid levels, stray
// starts, wait lengths) is randomized. Expected addresses come from the grid
// formula base + y*ROW_PITCH + x*PIX_STRIDE (mod 2^28), and expected timing
// comes from the protocol rules for request, wait, gap and done.
module tb_conv_rd_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [27:0] base_addr;
  logic        conv_ready;
  logic        in_valid;

  int sel;
  logic start_a, start_b, start_c;
  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  logic [27:0] rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_m;
  logic        addr_ena_a, addr_ena_b, addr_ena_c, addr_ena_m;
  logic [9:0]  pix_x_a, pix_x_b, pix_x_c, pix_x_m;
  logic [9:0]  pix_y_a, pix_y_b, pix_y_c, pix_y_m;
  logic        busy_a, busy_b, busy_c, busy_m;
  logic        done_a, done_b, done_c, done_m;

  int unsigned cfg_w      [3] = '{32'd3, 32'd1, 32'd1};
  int unsigned cfg_h      [3] = '{32'd2, 32'd3, 32'd1};
  logic [27:0] cfg_stride [3] = '{28'h040, 28'h040, 28'h040};
  logic [27:0] cfg_pitch  [3] = '{28'h100, 28'h080, 28'h800};

  int          n_checks = 0;
  int          n_errors = 0;
  logic        iv_last;
  logic [27:0] fbase;

  always #5 clk = ~clk;

  conv_rd_addr_gen #(.IMG_W(3), .IMG_H(2), .PIX_STRIDE(28'h040), .ROW_PITCH(28'h100)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_addr),
    .conv_ready(conv_ready), .in_valid(in_valid), .rd_addr(rd_addr_a),
    .addr_ena(addr_ena_a), .pix_x(pix_x_a), .pix_y(pix_y_a), .busy(busy_a),
    .frame_done(done_a));

  conv_rd_addr_gen #(.IMG_W(1), .IMG_H(3), .PIX_STRIDE(28'h040), .ROW_PITCH(28'h080)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr),
    .conv_ready(conv_ready), .in_valid(in_valid), .rd_addr(rd_addr_b),
    .addr_ena(addr_ena_b), .pix_x(pix_x_b), .pix_y(pix_y_b), .busy(busy_b),
    .frame_done(done_b));

  conv_rd_addr_gen #(.IMG_W(1), .IMG_H(1), .PIX_STRIDE(28'h040), .ROW_PITCH(28'h800)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .base_addr(base_addr),
    .conv_ready(conv_ready), .in_valid(in_valid), .rd_addr(rd_addr_c),
    .addr_ena(addr_ena_c), .pix_x(pix_x_c), .pix_y(pix_y_c), .busy(busy_c),
    .frame_done(done_c));

  // Route the selected instance's outputs to the checker.
  always_comb begin
    rd_addr_m  = rd_addr_a;
    addr_ena_m = addr_ena_a;
    pix_x_m    = pix_x_a;
    pix_y_m    = pix_y_a;
    busy_m     = busy_a;
    done_m     = done_a;
    case (sel)
      1: begin
        rd_addr_m = rd_addr_b; addr_ena_m = addr_ena_b; pix_x_m = pix_x_b;
        pix_y_m = pix_y_b; busy_m = busy_b; done_m = done_b;
      end
      2: begin
        rd_addr_m = rd_addr_c; addr_ena_m = addr_ena_c; pix_x_m = pix_x_c;
        pix_y_m = pix_y_c; busy_m = busy_c; done_m = done_c;
      end
      default: begin
        rd_addr_m = rd_addr_a;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (sel=%0d t=%0t): got 0x%0h expected 0x%0h", tag, sel, $time, got, exp);
    end
  endtask

  function automatic logic [27:0] exp_addr(input logic [27:0] b, input int x, input int y);
    longint unsigned t;
    t = longint'(b) + longint'(y) * longint'(cfg_pitch[sel]) + longint'(x) * longint'(cfg_stride[sel]);
    return t[27:0];
  endfunction

  // End the current cycle: remember this cycle's in_valid, move past the edge.
  task automatic tick();
    iv_last = in_valid;
    @(posedge clk);
    #1;
  endtask

  // A start pulse with a random base while busy must be ignored.
  task automatic poke_start();
    start     = ($urandom_range(0, 3) == 0);
    base_addr = 28'($urandom);
  endtask

  task automatic do_pixel(input int x, input int y, input int stall, input bit hold_in, input bit hold_out);
    logic [27:0] ea;
    int n;
    ea = exp_addr(fbase, x, y);
    for (int i = 0; i < stall; i++) begin
      conv_ready = 1'b0;
      in_valid   = hold_in ? 1'b1 : 1'($urandom_range(0, 1));
      poke_start();
      @(negedge clk);
      chk("stall_ena", 32'(addr_ena_m), 32'd0);
      chk("stall_busy", 32'(busy_m), 32'd1);
      chk("stall_x", 32'(pix_x_m), 32'(x));
      chk("stall_y", 32'(pix_y_m), 32'(y));
      tick();
    end
    conv_ready = 1'b1;
    in_valid   = hold_in ? 1'b1 : 1'($urandom_range(0, 1));
    poke_start();
    @(negedge clk);
    chk("issue_ena", 32'(addr_ena_m), 32'd1);
    chk("issue_addr", 32'(rd_addr_m), 32'(ea));
    chk("issue_x", 32'(pix_x_m), 32'(x));
    chk("issue_y", 32'(pix_y_m), 32'(y));
    tick();
    n = hold_in ? 2 : $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      in_valid   = hold_in ? 1'b1 : (iv_last ? 1'($urandom_range(0, 1)) : 1'b0);
      conv_ready = 1'($urandom_range(0, 1));
      poke_start();
      @(negedge clk);
      chk("wait_ena", 32'(addr_ena_m), 32'd1);
      chk("wait_addr", 32'(rd_addr_m), 32'(ea));
      tick();
    end
    if (iv_last) begin
      in_valid   = 1'b0;
      conv_ready = 1'($urandom_range(0, 1));
      poke_start();
      @(negedge clk);
      chk("low_ena", 32'(addr_ena_m), 32'd1);
      chk("low_addr", 32'(rd_addr_m), 32'(ea));
      tick();
    end
    in_valid   = 1'b1;
    conv_ready = 1'($urandom_range(0, 1));
    poke_start();
    @(negedge clk);
    chk("rise_ena", 32'(addr_ena_m), 32'd1);
    chk("rise_addr", 32'(rd_addr_m), 32'(ea));
    tick();
    in_valid   = hold_out ? 1'b1 : 1'($urandom_range(0, 1));
    conv_ready = 1'($urandom_range(0, 1));
    poke_start();
    @(negedge clk);
    chk("gap_ena", 32'(addr_ena_m), 32'd0);
    chk("gap_addr", 32'(rd_addr_m), 32'd0);
    chk("gap_busy", 32'(busy_m), 32'd1);
    chk("gap_done", 32'(done_m), 32'd0);
    tick();
  endtask

  task automatic run_frame(input logic [27:0] b, input int stall_px, input int level_px);
    int idx;
    int w;
    int h;
    w     = int'(cfg_w[sel]);
    h     = int'(cfg_h[sel]);
    fbase = b;
    conv_ready = 1'($urandom_range(0, 1));
    in_valid   = 1'b0;
    start      = 1'b1;
    base_addr  = b;
    @(negedge clk);
    chk("idle_busy", 32'(busy_m), 32'd0);
    chk("idle_ena", 32'(addr_ena_m), 32'd0);
    chk("idle_done", 32'(done_m), 32'd0);
    tick();
    start = 1'b0;
    idx   = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        do_pixel(x, y, (idx == stall_px) ? 5 : $urandom_range(0, 2),
                 idx == level_px + 1, idx == level_px);
        idx++;
      end
    end
    conv_ready = 1'($urandom_range(0, 1));
    in_valid   = 1'($urandom_range(0, 1));
    start      = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done_m), 32'd1);
    chk("done_busy", 32'(busy_m), 32'd0);
    chk("done_ena", 32'(addr_ena_m), 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_done", 32'(done_m), 32'd0);
    chk("post_busy", 32'(busy_m), 32'd0);
    chk("post_x", 32'(pix_x_m), 32'(w - 1));
    chk("post_y", 32'(pix_y_m), 32'(h - 1));
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(rd_addr_m), 32'd0);
    chk({tag, "_ena"}, 32'(addr_ena_m), 32'd0);
    chk({tag, "_x"}, 32'(pix_x_m), 32'd0);
    chk({tag, "_y"}, 32'(pix_y_m), 32'd0);
    chk({tag, "_busy"}, 32'(busy_m), 32'd0);
    chk({tag, "_done"}, 32'(done_m), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    rst_n = 1'b0; start = 1'b0; conv_ready = 1'b0; in_valid = 1'b0;
    base_addr = 28'h000_0000; sel = 0; iv_last = 1'b0; fbase = 28'h000_0000;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_all_zero("reset");
    end
    rst_n   = 1'b1;
    iv_last = 1'b0;
    @(posedge clk);
    #1;

    // Address walk with back-pressure at pixel 1 and a held in_valid at pixel 2->3.
    sel = 0;
    run_frame(28'h000_0100, 1, 2);
    // Wrap past the top of the 28-bit space.
    run_frame(28'hFFF_FF80, -10, -10);

    // Stray start during WAIT, then an asynchronous reset mid-WAIT.
    sel   = 0;
    fbase = 28'h0AB_C000;
    conv_ready = 1'b1; in_valid = 1'b0; start = 1'b1; base_addr = fbase;
    @(negedge clk);
    tick();
    start = 1'b0;
    do_pixel(0, 0, 0, 1'b0, 1'b0);
    conv_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_addr", 32'(rd_addr_m), 32'(exp_addr(fbase, 1, 0)));
    chk("pre_rst_x", 32'(pix_x_m), 32'd1);
    tick();
    start = 1'b1; base_addr = 28'h123_4560;
    @(negedge clk);
    chk("busy_start_addr", 32'(rd_addr_m), 32'(exp_addr(fbase, 1, 0)));
    chk("busy_start_ena", 32'(addr_ena_m), 32'd1);
    tick();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; iv_last = 1'b0;
    run_frame(28'h000_05A0, -10, -10);

    // Single-column geometry: every completion is a row step.
    sel = 1;
    run_frame(28'($urandom), 1, 0);
    // Single pixel.
    sel = 2;
    run_frame(28'h000_0200, -10, -10);

    // Randomized frames across all geometries.
    for (int f = 0; f < 9; f++) begin
      sel = $urandom_range(0, 2);
      np  = int'(cfg_w[sel] * cfg_h[sel]);
      run_frame(28'($urandom), $urandom_range(0, np), $urandom_range(0, np));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
